debounce_event_arbiter: RTL and testbench

- Debounces N_CH raw button/switch inputs using one shared millisecond prescaler and a small stable counter per channel.
- Each debounced level change becomes an event on a single valid/ready output port.
- Round-robin arbitration chooses among channels with pending events.
- Sits between board inputs and the UI/control FSM; downstream logic consumes discrete events instead of polling levels.

---
 rtl/debounce_pkg.sv | 19 +
 rtl/debounce_channel.sv | 47 ++++
 rtl/debounce_event_arbiter.sv | 138 +++++++++++++
 tb/tb_debounce_event_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and default parameters for the debounce event arbiter
package debounce_pkg;

  localparam int TICK_DIV_DEF     = 100000;
  localparam int STABLE_TICKS_DEF = 10;
  // Wide enough for the largest supported channel count (16).
  localparam int CH_W_MAX         = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [CH_W_MAX-1:0] ch;
    logic                level;
  } evt_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, stability counter and clean level for one input
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic clean,
  output logic change
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [1:0]    sync_ff;
  logic          old;
  logic [CW-1:0] cnt;
  logic          settled;

  assign settled = (cnt == CW'(STABLE_TICKS)) && (old != clean);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      old     <= 1'b0;
      cnt     <= '0;
      clean   <= 1'b0;
      change  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
      // Any disagreement restarts the stability window, tick or not.
      if (sync_ff[1] != old) begin
        old <= sync_ff[1];
        cnt <= '0;
      end else if (tick && (cnt < CW'(STABLE_TICKS))) begin
        cnt <= cnt + 1'b1;
      end
      if (settled) begin
        clean <= old;
      end
      change <= settled;
    end
  end

endmodule

// File: rtl/debounce_event_arbiter.sv
// rtl/debounce_event_arbiter.sv - N-channel debouncer with round-robin valid/ready event port
// Optional DEBOUNCE_OVERRUN_EN adds sticky per-channel overrun flags.
module debounce_event_arbiter
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [N_CH-1:0] bouncey_in,
  output logic [N_CH-1:0] clean_out,
  output logic            evt_valid_out,
  input  logic            evt_ready_in,
  output logic [CH_W-1:0] evt_ch_out,
  output logic            evt_level_out
`ifdef DEBOUNCE_OVERRUN_EN
  ,
  output logic [N_CH-1:0] overrun_out,
  input  logic            clr_overrun_in
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic [N_CH-1:0] change;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .tick  (tick),
      .raw   (bouncey_in[i]),
      .clean (clean_out[i]),
      .change(change[i])
    );
  end

  arb_state_t      state, state_next;
  evt_t            evt;
  logic [N_CH-1:0] pending, grant_clr;
  logic [CH_W-1:0] rr_ptr, pick, off_ch;
  logic            found, load, handshake, rearm;

  assign off_ch = CH_W'(evt.ch);

  // Walk downward so the smallest offset from rr_ptr is the last one written.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % N_CH]) begin
        found = 1'b1;
        pick  = CH_W'((int'(rr_ptr) + k) % N_CH);
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    handshake  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load       = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready_in) begin
          handshake  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A level change seen on the offered channel keeps its pending bit alive.
  assign grant_clr = (handshake && !rearm) ? (N_CH'(1) << off_ch) : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      evt     <= '0;
      pending <= '0;
      rr_ptr  <= '0;
      rearm   <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= (pending & ~grant_clr) | change;
      if (load) begin
        evt.ch    <= CH_W_MAX'(pick);
        evt.level <= clean_out[pick];
      end
      if ((state == IDLE) || handshake) begin
        rearm <= 1'b0;
      end else if (change[off_ch]) begin
        rearm <= 1'b1;
      end
      if (handshake) begin
        rr_ptr <= (off_ch == CH_W'(N_CH - 1)) ? '0 : off_ch + 1'b1;
      end
    end
  end

  assign evt_valid_out = (state == OFFER);
  assign evt_ch_out    = off_ch;
  assign evt_level_out = evt.level;

`ifdef DEBOUNCE_OVERRUN_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      overrun_out <= '0;
    end else begin
      overrun_out <= (clr_overrun_in ? '0 : overrun_out) | (change & pending);
    end
  end
`endif

endmodule

// File: tb/tb_debounce_event_arbiter.sv
// tb/tb_debounce_event_arbiter.sv - scoreboard bench for debounce_event_arbiter
module tb_debounce_event_arbiter;

  localparam int N_CH = 4;
  localparam int TICK_DIV = 4;
  localparam int STABLE_TICKS = 3;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [3:0] bouncey_in = 4'b0000;
  logic [3:0] clean_out;
  logic       evt_valid_out;
  logic       evt_ready_in = 1'b0;
  logic [1:0] evt_ch_out;
  logic       evt_level_out;
`ifdef DEBOUNCE_OVERRUN_EN
  logic [3:0] overrun_out;
  logic       clr_overrun_in = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    int   ch;
    logic level;
  } exp_t;

  exp_t exp_q[$];
  int   hs_cyc[$];

  debounce_event_arbiter #(
    .N_CH(N_CH),
    .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .bouncey_in(bouncey_in),
    .clean_out(clean_out),
    .evt_valid_out(evt_valid_out),
    .evt_ready_in(evt_ready_in),
    .evt_ch_out(evt_ch_out),
    .evt_level_out(evt_level_out)
`ifdef DEBOUNCE_OVERRUN_EN
    ,
    .overrun_out(overrun_out),
    .clr_overrun_in(clr_overrun_in)
`endif
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_evt(input int ch, input logic level);
    exp_t e;
    e.ch = ch;
    e.level = level;
    exp_q.push_back(e);
  endtask

  task automatic wait_clean(input int ch, input logic val, input string nm);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_in);
      if (clean_out[ch] == val) break;
    end
    check(nm, clean_out[ch], val);
  endtask

  task automatic wait_valid(input string nm);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_in);
      if (evt_valid_out) break;
    end
    check(nm, evt_valid_out, 1);
  endtask

  task automatic wait_drain(input string nm);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0) break;
    end
    check(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: every accepted event is popped from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_n_in && evt_valid_out && evt_ready_in) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_event: got ch=%0d level=%0d, expected no event",
                   evt_ch_out, evt_level_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("evt_ch", evt_ch_out, e.ch);
          check("evt_level", evt_level_out, e.level);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int m;
    int vcnt;
    int unstable;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_clean", clean_out, 0);
    check("rst_valid", evt_valid_out, 0);
    check("rst_ch", evt_ch_out, 0);
    check("rst_level", evt_level_out, 0);
    step();
    rst_n_in = 1'b1;
    evt_ready_in = 1'b1;
    vcnt = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (evt_valid_out) vcnt++;
    end
    check("idle_after_reset", vcnt, 0);

    // Clean press on ch2: latency and valid two cycles after clean_out
    expect_evt(2, 1'b1);
    step();
    bouncey_in[2] = 1'b1;
    m = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_in);
      m++;
      if (clean_out[2]) break;
    end
    check("press_clean", clean_out[2], 1);
    check("press_latency_in_13_16", (m >= 13) && (m <= 16), 1);
    @(negedge clk_in);
    check("press_valid_plus1", evt_valid_out, 0);
    @(negedge clk_in);
    check("press_valid_plus2", evt_valid_out, 1);
    wait_drain("press_drained");
    repeat (3) @(negedge clk_in);
    check("press_pending_cleared", evt_valid_out, 0);

    // Bounce on ch0, then settle high
    step();
    for (int t = 0; t < 8; t++) begin
      bouncey_in[0] = ~bouncey_in[0];
      repeat (5) step();
    end
    check("bounce_no_clean", clean_out[0], 0);
    expect_evt(0, 1'b1);
    bouncey_in[0] = 1'b1;
    wait_clean(0, 1'b1, "bounce_settled");
    wait_drain("bounce_drained");

    // Round robin from rr_ptr=1: ch0, ch1, ch3 change together
    expect_evt(1, 1'b1);
    expect_evt(3, 1'b1);
    expect_evt(0, 1'b0);
    hs_cyc.delete();
    step();
    bouncey_in = 4'b1110;
    wait_drain("rr_drained");
    check("rr_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("rr_gap_1_3", hs_cyc[1] - hs_cyc[0], 2);
      check("rr_gap_3_0", hs_cyc[2] - hs_cyc[1], 2);
    end

    // Return ch1 to 0 before backpressure
    expect_evt(1, 1'b0);
    step();
    bouncey_in[1] = 1'b0;
    wait_drain("prep_drained");

    // Backpressure: offered {1,1} held while ch1 settles back to 0
    step();
    evt_ready_in = 1'b0;
    expect_evt(1, 1'b1);
    expect_evt(1, 1'b0);
    bouncey_in[1] = 1'b1;
    wait_valid("bp_offer_valid");
    check("bp_offer_ch", evt_ch_out, 1);
    check("bp_offer_level", evt_level_out, 1);
    step();
    bouncey_in[1] = 1'b0;
    unstable = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_in);
      if (!(evt_valid_out && evt_ch_out == 2'd1 && evt_level_out)) unstable++;
      if (!clean_out[1]) break;
    end
    check("bp_settle_back", clean_out[1], 0);
    repeat (5) begin
      @(negedge clk_in);
      if (!(evt_valid_out && evt_ch_out == 2'd1 && evt_level_out)) unstable++;
    end
    check("bp_payload_stable", unstable, 0);
    step();
    evt_ready_in = 1'b1;
    wait_drain("bp_drained");

    // Reset mid-OFFER
    step();
    evt_ready_in = 1'b0;
    bouncey_in[2] = 1'b0;
    wait_valid("prereset_offer");
    step();
    rst_n_in = 1'b0;
    bouncey_in = 4'b0000;
    #1;
    check("midrst_valid", evt_valid_out, 0);
    check("midrst_ch", evt_ch_out, 0);
    check("midrst_level", evt_level_out, 0);
    check("midrst_clean", clean_out, 0);
`ifdef DEBOUNCE_OVERRUN_EN
    check("midrst_overrun", overrun_out, 0);
`endif
    repeat (3) step();
    rst_n_in = 1'b1;
    evt_ready_in = 1'b1;
    vcnt = 0;
    repeat (30) begin
      @(negedge clk_in);
      if (evt_valid_out) vcnt++;
    end
    check("idle_after_midrst", vcnt, 0);

    // Two debounced changes on ch3 under backpressure
    step();
    evt_ready_in = 1'b0;
    expect_evt(3, 1'b1);
    expect_evt(3, 1'b0);
    bouncey_in[3] = 1'b1;
    wait_clean(3, 1'b1, "ovr_first_change");
    step();
    bouncey_in[3] = 1'b0;
    wait_clean(3, 1'b0, "ovr_second_change");
    repeat (2) @(negedge clk_in);
`ifdef DEBOUNCE_OVERRUN_EN
    check("overrun_set", overrun_out, 4'b1000);
    step();
    clr_overrun_in = 1'b1;
    step();
    clr_overrun_in = 1'b0;
    @(negedge clk_in);
    check("overrun_cleared", overrun_out, 0);
`endif
    check("ovr_offer_level", evt_level_out, 1);
    step();
    evt_ready_in = 1'b1;
    wait_drain("ovr_drained");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
